rr_arb16: RTL and testbench

RR_ARB16 -- requirements
Module: rr_arb16

---
 rtl/rr_arb16.sv | 132 +++++++++++++
 tb/tb_rr_arb16.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-way round-robin arbiter with registered one-hot grant and early release
// Optional hold-timeout enabled by defining RR_ARB16_TIMEOUT_EN.
module rr_arb16 #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
      $error("rr_arb16: MAX_HOLD must be within 1..15");
   end

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [15:0] gnt_q, gnt_d;
   logic [3:0]  gnt_idx_q, gnt_idx_d;
   logic        gnt_valid_q, gnt_valid_d;

   logic        found;
   logic [3:0]  win;
   logic [3:0]  cand;
   logic        hold_expired;
   logic        release_hit;

`ifdef RR_ARB16_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   logic [3:0] hcnt_q, hcnt_d;

   assign hold_expired = (state_q == GRANT) && (hcnt_q == HOLD_LAST);
`else
   assign hold_expired = 1'b0;
`endif

   // done and a dropped request in the same cycle collapse into one release
   assign release_hit = !req[gnt_idx_q] || done || hold_expired;

   // Upward search from ptr; 4-bit arithmetic provides the 15 -> 0 wrap.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      cand  = ptr_q;
      for (int k = 0; k < 16; k++) begin
         cand = ptr_q + 4'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB16_TIMEOUT_EN
      hcnt_d      = hcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = GRANT;
               gnt_d       = 16'd1 << win;
               gnt_idx_d   = win;
               gnt_valid_d = 1'b1;
`ifdef RR_ARB16_TIMEOUT_EN
               hcnt_d      = 4'd0;
`endif
            end
         end
         GRANT: begin
            if (release_hit) begin
               state_d     = IDLE;
               gnt_d       = 16'd0;
               gnt_idx_d   = 4'd0;
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx_q + 4'd1;
            end else begin
`ifdef RR_ARB16_TIMEOUT_EN
               hcnt_d      = hcnt_q + 4'd1;
`endif
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = 16'd0;
            gnt_idx_d   = 4'd0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 4'd0;
         gnt_q       <= 16'd0;
         gnt_idx_q   <= 4'd0;
         gnt_valid_q <= 1'b0;
`ifdef RR_ARB16_TIMEOUT_EN
         hcnt_q      <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
`ifdef RR_ARB16_TIMEOUT_EN
         hcnt_q      <= hcnt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - directed self-checking bench for rr_arb16
module tb_rr_arb16;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;

   int n_total = 0;
   int n_bad   = 0;
   bit run_inv = 0;

   rr_arb16 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      done  = 1'b0;
      req   = 16'h0000;
      step();
      rst_n = 1'b1;
   endtask

   // Output-structure invariant, checked on every falling edge
   always @(negedge clk) begin
      if (run_inv) begin
         logic [3:0] exp_idx;
         logic       onehot_ok;
         exp_idx   = 4'd0;
         onehot_ok = (gnt == 16'd0) || ((gnt & (gnt - 16'd1)) == 16'd0);
         for (int i = 0; i < 16; i++) if (gnt[i]) exp_idx = 4'(i);
         chk("inv_onehot", {31'd0, onehot_ok}, 32'd1);
         chk("inv_idx", {28'd0, gnt_idx}, {28'd0, exp_idx});
         chk("inv_valid", {31'd0, gnt_valid}, {31'd0, |gnt});
      end
   end

   initial begin
      int held;
      rst_n = 1'b0;
      req   = 16'h0000;
      done  = 1'b0;
      step();
      step();
      run_inv = 1;
      chk("rst_gnt", {16'd0, gnt}, 32'h0);
      chk("rst_idx", {28'd0, gnt_idx}, 32'd0);
      chk("rst_valid", {31'd0, gnt_valid}, 32'd0);

      // basic grant, release, pointer advance
      rst_n = 1'b1;
      step();
      chk("idle_noreq", {31'd0, gnt_valid}, 32'd0);
      req = 16'h0001;
      step();
      chk("basic_gnt", {16'd0, gnt}, 32'h0001);
      chk("basic_idx", {28'd0, gnt_idx}, 32'd0);
      chk("basic_valid", {31'd0, gnt_valid}, 32'd1);
      req = 16'h0000;
      step();
      chk("basic_rel", {16'd0, gnt}, 32'h0);
      req = 16'h0003;
      step();
      chk("ptr_adv_idx", {28'd0, gnt_idx}, 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("done_rel", {31'd0, gnt_valid}, 32'd0);
      req = 16'h0000;
      step();

      // fairness sweep with done each grant cycle
      do_reset();
      req = 16'hFFFF;
      for (int k = 0; k <= 16; k++) begin
         step();
         chk("fair_valid", {31'd0, gnt_valid}, 32'd1);
         chk("fair_idx", {28'd0, gnt_idx}, 32'(k % 16));
         done = 1'b1;
         step();
         done = 1'b0;
         chk("fair_gap", {31'd0, gnt_valid}, 32'd0);
      end
      req = 16'h0000;
      step();

      // wrap: bring ptr to 15 via a grant on 14
      do_reset();
      req = 16'h4000;
      step();
      chk("wrap_pre", {28'd0, gnt_idx}, 32'd14);
      req = 16'h0000;
      step();
      req = 16'h8001;
      step();
      chk("wrap_15", {28'd0, gnt_idx}, 32'd15);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      chk("wrap_0", {28'd0, gnt_idx}, 32'd0);
      chk("wrap_0v", {31'd0, gnt_valid}, 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      chk("wrap_no0twice", {28'd0, gnt_idx}, 32'd15);
      // other bits toggling must not disturb the current holder
      req = 16'h8FF1;
      step();
      req = 16'h8002;
      step();
      chk("other_bits", {16'd0, gnt}, 32'h8000);
      // dropped request plus done in one cycle: single pointer advance
      req  = 16'h0003;
      done = 1'b1;
      step();
      done = 1'b0;
      chk("dual_rel", {31'd0, gnt_valid}, 32'd0);
      step();
      chk("dual_ptr", {28'd0, gnt_idx}, 32'd0);
      req = 16'h0000;
      step();

      // hold behaviour
      do_reset();
      req = 16'h0010;
      step();
      chk("to_first", {28'd0, gnt_idx}, 32'd4);
`ifdef RR_ARB16_TIMEOUT_EN
      for (int k = 0; k < 3; k++) begin
         step();
         chk("to_held", {31'd0, gnt_valid}, 32'd1);
      end
      step();
      chk("to_forced", {31'd0, gnt_valid}, 32'd0);
      step();
      chk("to_regrant", {27'd0, gnt_valid, gnt_idx}, {27'd0, 1'b1, 4'd4});
`else
      held = 0;
      for (int k = 0; k < 110; k++) begin
         step();
         if (gnt_valid && gnt_idx == 4'd4) held++;
      end
      chk("no_timeout", 32'(held), 32'd110);
`endif
      req = 16'h0000;
      step();

      // reset in the middle of a grant
      do_reset();
      req = 16'h0200;
      step();
      chk("mid_pre", {28'd0, gnt_idx}, 32'd9);
      rst_n = 1'b0;
      step();
      chk("mid_rst_gnt", {16'd0, gnt}, 32'h0);
      chk("mid_rst_valid", {31'd0, gnt_valid}, 32'd0);
      rst_n = 1'b1;
      req   = 16'h0201;
      step();
      chk("mid_ptr0", {28'd0, gnt_idx}, 32'd0);
      chk("mid_ptr0v", {31'd0, gnt_valid}, 32'd1);
      req = 16'h0000;
      step();

      run_inv = 0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
